midi_voice_allocator: RTL and testbench

- Polyphonic voice scheduler between the MIDI message decoder and the synthesizer voice bank.
- Takes decoded channel messages (status nibble, two data bytes, valid pulse) and shares NUM_VOICES oscillator/envelope voices among incoming notes.
- Handles note-on allocation, note-off release, same-pitch retrigger, oldest-voice stealing and All-Notes-Off.
- Drives per-voice gate/pitch/velocity registers that are read by the voice bank.

---
 rtl/midi_voice_allocator.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: shares NUM_VOICES synth voices among MIDI notes.
// Sequential voice scan, oldest-voice stealing, one-deep pending buffer.
module midi_voice_allocator #(
  parameter  int NUM_VOICES = 4,
  parameter  int AGE_W      = 4,
  localparam int IW         = $clog2(NUM_VOICES)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [3:0]              status_in,
  input  logic [7:0]              data_byte1_in,
  input  logic [7:0]              data_byte2_in,
  input  logic                    valid_in,
  output logic                    busy_out,
  output logic [NUM_VOICES-1:0]   gate_out,
  output logic [7*NUM_VOICES-1:0] pitch_out,
  output logic [7*NUM_VOICES-1:0] velocity_out,
  output logic                    voice_update_out,
  output logic [IW-1:0]           voice_idx_out,
  output logic                    steal_out,
  output logic                    all_off_out,
  output logic                    dropped_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [1:0] C_OFF = 2'd0;
  localparam logic [1:0] C_ON  = 2'd1;
  localparam logic [1:0] C_ALL = 2'd2;

  typedef struct packed {
    logic [1:0] cls;
    logic [6:0] pitch;
    logic [6:0] vel;
  } msg_t;

  typedef logic [NUM_VOICES-1:0][6:0]       v7_t;
  typedef logic [NUM_VOICES-1:0][AGE_W-1:0] age_t;

  msg_t                  in_msg;
  logic                  in_rel;
  logic                  unused_in;

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  msg_t                  cur_q, cur_d;
  msg_t                  pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;

  logic                  mfound_q, mfound_d;
  logic [IW-1:0]         midx_q, midx_d;
  logic                  ffound_q, ffound_d;
  logic [IW-1:0]         fidx_q, fidx_d;
  logic                  ofound_q, ofound_d;
  logic [IW-1:0]         oidx_q, oidx_d;
  logic [AGE_W-1:0]      oage_q, oage_d;

  logic [NUM_VOICES-1:0] gate_q, gate_d;
  v7_t                   pitch_q, pitch_d;
  v7_t                   vel_q, vel_d;
  age_t                  age_q, age_d;

  logic                  upd_q, upd_d;
  logic                  steal_q, steal_d;
  logic                  alloff_q, alloff_d;
  logic                  drop_q, drop_d;
  logic [IW-1:0]         vidx_q, vidx_d;
  logic [IW-1:0]         tgt;

  logic [NUM_VOICES-1:0] gate_o_q;
  v7_t                   pitch_o_q;
  v7_t                   vel_o_q;
  logic                  upd_o_q;
  logic                  steal_o_q;
  logic                  alloff_o_q;
  logic [IW-1:0]         vidx_o_q;

  assign unused_in = ^{status_in[3], data_byte1_in[7],
                       data_byte2_in[7]};

  always_comb begin
    in_msg.pitch = data_byte1_in[6:0];
    in_msg.vel   = data_byte2_in[6:0];
    in_msg.cls   = C_OFF;
    in_rel       = 1'b0;
    unique case (1'b1)
      status_in[2:0] == 3'd0: in_rel = valid_in;
      status_in[2:0] == 3'd1: begin
        in_rel = valid_in;
        if (data_byte2_in[6:0] != 7'd0) in_msg.cls = C_ON;
      end
      status_in[2:0] == 3'd3 &&
      data_byte1_in[6:0] == 7'd123: begin
        in_rel     = valid_in;
        in_msg.cls = C_ALL;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    mfound_d    = mfound_q;
    midx_d      = midx_q;
    ffound_d    = ffound_q;
    fidx_d      = fidx_q;
    ofound_d    = ofound_q;
    oidx_d      = oidx_q;
    oage_d      = oage_q;
    gate_d      = gate_q;
    pitch_d     = pitch_q;
    vel_d       = vel_q;
    age_d       = age_q;
    upd_d       = 1'b0;
    steal_d     = 1'b0;
    alloff_d    = 1'b0;
    drop_d      = 1'b0;
    vidx_d      = vidx_q;
    tgt         = '0;

    case (state_q)
      S_IDLE: begin
        if (pend_full_q) begin
          cur_d       = pend_q;
          pend_full_d = in_rel;
          if (in_rel) pend_d = in_msg;
          state_d     = S_SCAN;
          idx_d       = '0;
          mfound_d    = 1'b0;
          ffound_d    = 1'b0;
          ofound_d    = 1'b0;
        end else if (in_rel) begin
          cur_d    = in_msg;
          state_d  = S_SCAN;
          idx_d    = '0;
          mfound_d = 1'b0;
          ffound_d = 1'b0;
          ofound_d = 1'b0;
        end
      end

      S_SCAN: begin
        if (gate_q[idx_q] && !mfound_q &&
            pitch_q[idx_q] == cur_q.pitch) begin
          mfound_d = 1'b1;
          midx_d   = idx_q;
        end
        if (!gate_q[idx_q] && !ffound_q) begin
          ffound_d = 1'b1;
          fidx_d   = idx_q;
        end
        // strict compare keeps the lowest index on equal age
        if (gate_q[idx_q] &&
            (!ofound_q || age_q[idx_q] > oage_q)) begin
          ofound_d = 1'b1;
          oidx_d   = idx_q;
          oage_d   = age_q[idx_q];
        end
        if (idx_q == IW'(NUM_VOICES - 1)) state_d = S_COMMIT;
        else idx_d = idx_q + 1'b1;
      end

      S_COMMIT: begin
        unique case (cur_q.cls)
          C_ON: begin
            tgt = oidx_q;
            if (mfound_q) tgt = midx_q;
            else if (ffound_q) tgt = fidx_q;
            steal_d = !mfound_q && !ffound_q;
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (gate_q[v] && IW'(v) != tgt &&
                  age_q[v] != '1)
                age_d[v] = age_q[v] + 1'b1;
            end
            gate_d[tgt]  = 1'b1;
            pitch_d[tgt] = cur_q.pitch;
            vel_d[tgt]   = cur_q.vel;
            age_d[tgt]   = '0;
            upd_d        = 1'b1;
            vidx_d       = tgt;
          end
          C_OFF: begin
            if (mfound_q) begin
              gate_d[midx_q] = 1'b0;
              upd_d          = 1'b1;
              vidx_d         = midx_q;
            end
          end
          C_ALL: begin
            gate_d   = '0;
            age_d    = '0;
            alloff_d = 1'b1;
          end
          default: ;
        endcase
        if (pend_full_q) begin
          cur_d       = pend_q;
          pend_full_d = 1'b0;
          state_d     = S_SCAN;
          idx_d       = '0;
          mfound_d    = 1'b0;
          ffound_d    = 1'b0;
          ofound_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // arrivals while busy see the buffer as it was before any handoff
    if (state_q != S_IDLE && in_rel) begin
      if (pend_full_q) begin
        drop_d = 1'b1;
      end else begin
        pend_d      = in_msg;
        pend_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      mfound_q    <= 1'b0;
      midx_q      <= '0;
      ffound_q    <= 1'b0;
      fidx_q      <= '0;
      ofound_q    <= 1'b0;
      oidx_q      <= '0;
      oage_q      <= '0;
      gate_q      <= '0;
      pitch_q     <= '0;
      vel_q       <= '0;
      age_q       <= '0;
      upd_q       <= 1'b0;
      steal_q     <= 1'b0;
      alloff_q    <= 1'b0;
      drop_q      <= 1'b0;
      vidx_q      <= '0;
      gate_o_q    <= '0;
      pitch_o_q   <= '0;
      vel_o_q     <= '0;
      upd_o_q     <= 1'b0;
      steal_o_q   <= 1'b0;
      alloff_o_q  <= 1'b0;
      vidx_o_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      mfound_q    <= mfound_d;
      midx_q      <= midx_d;
      ffound_q    <= ffound_d;
      fidx_q      <= fidx_d;
      ofound_q    <= ofound_d;
      oidx_q      <= oidx_d;
      oage_q      <= oage_d;
      gate_q      <= gate_d;
      pitch_q     <= pitch_d;
      vel_q       <= vel_d;
      age_q       <= age_d;
      upd_q       <= upd_d;
      steal_q     <= steal_d;
      alloff_q    <= alloff_d;
      drop_q      <= drop_d;
      vidx_q      <= vidx_d;
      gate_o_q    <= gate_q;
      pitch_o_q   <= pitch_q;
      vel_o_q     <= vel_q;
      upd_o_q     <= upd_q;
      steal_o_q   <= steal_q;
      alloff_o_q  <= alloff_q;
      vidx_o_q    <= vidx_q;
    end
  end

  assign busy_out         = state_q != S_IDLE;
  assign gate_out         = gate_o_q;
  assign pitch_out        = pitch_o_q;
  assign velocity_out     = vel_o_q;
  assign voice_update_out = upd_o_q;
  assign voice_idx_out    = vidx_o_q;
  assign steal_out        = steal_o_q;
  assign all_off_out      = alloff_o_q;
  assign dropped_out      = drop_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator: random and directed notes against a
// behavioural voice model; a monitor pops expected updates on each pulse.
module tb_midi_voice_allocator;
  localparam int NV   = 4;
  localparam int AMAX = 15;
  localparam int ANY  = -1;
  localparam int DROP = -2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  status = '0;
  logic [7:0]  b1 = '0;
  logic [7:0]  b2 = '0;
  logic        valid = 1'b0;
  logic        busy;
  logic [3:0]  gate;
  logic [27:0] pitch;
  logic [27:0] vel;
  logic        upd;
  logic [1:0]  vidx;
  logic        steal;
  logic        alloff;
  logic        dropped;

  always #5 clk = ~clk;

  midi_voice_allocator dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .status_in       (status),
    .data_byte1_in   (b1),
    .data_byte2_in   (b2),
    .valid_in        (valid),
    .busy_out        (busy),
    .gate_out        (gate),
    .pitch_out       (pitch),
    .velocity_out    (vel),
    .voice_update_out(upd),
    .voice_idx_out   (vidx),
    .steal_out       (steal),
    .all_off_out     (alloff),
    .dropped_out     (dropped)
  );

  typedef struct {
    bit          is_all;
    int          idx;
    bit          stl;
    logic [3:0]  g;
    logic [27:0] p;
    logic [27:0] v;
    int          t;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int drops_seen = 0;
  int exp_drops = 0;

  bit m_gate[NV];
  int m_pitch[NV];
  int m_vel[NV];
  int m_age[NV];
  int m_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 0; m_pitch[v] = 0; m_vel[v] = 0; m_age[v] = 0;
    end
    m_last = 0;
  endtask

  task automatic push(input bit is_all, input bit stl, input int t);
    exp_t e;
    e.is_all = is_all;
    e.idx = m_last;
    e.stl = stl;
    e.t = t;
    e.g = '0;
    e.p = '0;
    e.v = '0;
    for (int v = 0; v < NV; v++) begin
      e.g[v] = m_gate[v];
      e.p[7*v +: 7] = 7'(m_pitch[v]);
      e.v[7*v +: 7] = 7'(m_vel[v]);
    end
    exp_q.push_back(e);
  endtask

  task automatic model_apply(input logic [3:0] st, input logic [7:0] x1,
                             input logic [7:0] x2, input int t);
    int p, vl, tg, best;
    bit stl;
    p = int'(x1[6:0]);
    vl = int'(x2[6:0]);
    tg = -1;
    stl = 0;
    if (st[2:0] == 3'd1 && vl != 0) begin
      for (int v = 0; v < NV; v++)
        if (tg < 0 && m_gate[v] && m_pitch[v] == p) tg = v;
      for (int v = 0; v < NV; v++)
        if (tg < 0 && !m_gate[v]) tg = v;
      if (tg < 0) begin
        stl = 1;
        best = -1;
        for (int v = 0; v < NV; v++)
          if (m_gate[v] && m_age[v] > best) begin
            best = m_age[v];
            tg = v;
          end
      end
      for (int v = 0; v < NV; v++)
        if (m_gate[v] && v != tg)
          m_age[v] = (m_age[v] >= AMAX) ? AMAX : m_age[v] + 1;
      m_gate[tg] = 1;
      m_pitch[tg] = p;
      m_vel[tg] = vl;
      m_age[tg] = 0;
      m_last = tg;
      push(0, stl, t);
    end else if (st[2:0] == 3'd0 || st[2:0] == 3'd1) begin
      for (int v = 0; v < NV; v++)
        if (tg < 0 && m_gate[v] && m_pitch[v] == p) tg = v;
      if (tg >= 0) begin
        m_gate[tg] = 0;
        m_last = tg;
        push(0, 0, t);
      end
    end else if (st[2:0] == 3'd3 && p == 123) begin
      for (int v = 0; v < NV; v++) begin
        m_gate[v] = 0;
        m_age[v] = 0;
      end
      push(1, 0, t);
    end
  endtask

  // caller is at posedge+1; t: expected pulse cycle, ANY, or DROP
  task automatic send(input logic [3:0] st, input logic [7:0] x1,
                      input logic [7:0] x2, input int t);
    status = st;
    b1 = x1;
    b2 = x2;
    valid = 1'b1;
    if (t == DROP) exp_drops++;
    else model_apply(st, x1, x2, t);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) begin
      n_err++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic pick(output logic [3:0] st, output logic [7:0] x1,
                      output logic [7:0] x2);
    int k;
    k = $urandom_range(0, 11);
    if (k < 3) st = 4'd0;
    else if (k < 9) st = 4'd1;
    else if (k == 9) st = 4'd3;
    else st = 4'(2 + 2 * $urandom_range(0, 2));
    st[3] = 1'($urandom_range(0, 1));
    x1 = 8'(60 + $urandom_range(0, 7));
    x1[7] = 1'($urandom_range(0, 1));
    if (st[2:0] == 3'd3 && $urandom_range(0, 2) != 0) x1[6:0] = 7'd123;
    x2 = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 7) == 0) x2[6:0] = 7'd0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dropped) drops_seen++;
      if (upd || alloff) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse: upd=%0b alloff=%0b, expected none",
                   upd, alloff);
        end else begin
          me = exp_q.pop_front();
          chk("update_pulse", 64'(upd), 64'(!me.is_all));
          chk("alloff_pulse", 64'(alloff), 64'(me.is_all));
          chk("voice_idx", 64'(vidx), 64'(me.idx));
          chk("steal", 64'(steal), 64'(me.stl));
          chk("gate", 64'(gate), 64'(me.g));
          chk("pitch", 64'(pitch), 64'(me.p));
          chk("velocity", 64'(vel), 64'(me.v));
          if (me.t >= 0) chk("latency", 64'(cyc), 64'(me.t));
        end
      end
    end
  end

  initial begin
    logic [3:0] st, st2;
    logic [7:0] x1, x2, y1, y2;
    int c0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_gate", 64'(gate), 0);
    chk("rst_pitch", 64'(pitch), 0);
    chk("rst_vel", 64'(vel), 0);
    chk("rst_upd", 64'(upd), 0);
    chk("rst_idx", 64'(vidx), 0);
    chk("rst_steal", 64'(steal), 0);
    chk("rst_alloff", 64'(alloff), 0);
    chk("rst_dropped", 64'(dropped), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(4'h1, 8'd60, 8'd100, cyc + 7); wait_idle();
    send(4'h1, 8'd62, 8'd80, cyc + 7); wait_idle();
    send(4'h1, 8'd64, 8'd81, cyc + 7); wait_idle();
    send(4'h1, 8'd65, 8'd82, cyc + 7); wait_idle();
    send(4'h1, 8'd67, 8'd83, cyc + 7); wait_idle();
    send(4'h3, 8'd123, 8'd0, cyc + 7); wait_idle();

    send(4'h1, 8'd60, 8'd90, cyc + 7); wait_idle();
    send(4'h1, 8'd62, 8'd91, cyc + 7); wait_idle();
    send(4'h1, 8'd62, 8'd0, cyc + 7); wait_idle();
    send(4'h0, 8'd70, 8'd64, cyc + 7); wait_idle();
    send(4'h1, 8'd62, 8'd90, cyc + 7); wait_idle();
    send(4'h1, 8'd62, 8'd40, cyc + 7); wait_idle();
    send(4'h3, 8'd123, 8'd0, cyc + 7); wait_idle();

    send(4'h2, 8'd60, 8'd50, ANY);
    chk("ignored_busy", 64'(busy), 0);
    wait_idle();

    c0 = cyc;
    send(4'h1, 8'd48, 8'd10, c0 + 7);
    send(4'h1, 8'd50, 8'd11, c0 + 12);
    send(4'h1, 8'd52, 8'd12, DROP);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(4'h0, 8'd48, 8'd0, DROP);
    wait_idle();

    send(4'h3, 8'd123, 8'd0, cyc + 7); wait_idle();
    send(4'h1, 8'd60, 8'd20, cyc + 7); wait_idle();
    send(4'h1, 8'd61, 8'd21, cyc + 7); wait_idle();
    for (int i = 0; i < 13; i++) begin
      send(4'h1, 8'd61, 8'(30 + i), cyc + 7);
      wait_idle();
    end
    send(4'h1, 8'd62, 8'd22, cyc + 7); wait_idle();
    send(4'h1, 8'd63, 8'd23, cyc + 7); wait_idle();
    send(4'h1, 8'd64, 8'd24, cyc + 7); wait_idle();

    send(4'h1, 8'd72, 8'd90, ANY);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_gate", 64'(gate), 0);
    chk("midrst_pitch", 64'(pitch), 0);
    chk("midrst_vel", 64'(vel), 0);
    chk("midrst_busy", 64'(busy), 0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(4'h1, 8'd70, 8'd33, cyc + 7); wait_idle();

    for (int i = 0; i < 60; i++) begin
      wait_idle();
      pick(st, x1, x2);
      if ($urandom_range(0, 3) == 0) begin
        pick(st2, y1, y2);
        send(st, x1, x2, ANY);
        send(st2, y1, y2, ANY);
      end else begin
        send(st, x1, x2, cyc + 7);
      end
    end

    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 0);
    chk("drop_count", 64'(drops_seen), 64'(exp_drops));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
